regfile_mp: RTL
===============

# regfile_mp

Multi-port register file with per-register scoreboard for the pipelined core: NR combinational read ports, NW synchronous write ports with fixed priority, an optional hardwired-zero register, and a busy-bit scoreboard for RAW hazard detection in decode. It replaces the single-write, dual-read file in the decode stage. It lets wider or dual-issue pipelines share one architectural register state.

## Interface

Parameters:
- AW, 5, register address width; depth = 2**AW
- DW, 32, data width
- NR, 2, number of read ports (1..4)
- NW, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1: register 0 reads as 0, ignores writes, never busy

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- wr_en  input  NW  write enable per write port
- wr_addr  input  NW*AW  write address, port k at [k*AW +: AW]
- wr_data  input  NW*DW  write data, port k at [k*DW +: DW]
- rd_addr  input  NR*AW  read address, port j at [j*AW +: AW]
- rd_data  output  NR*DW  read data, port j at [j*DW +: DW]
- rd_busy  output  NR  scoreboard busy bit of rd_addr port j
- sb_set_en  input  1  mark sb_set_addr busy (instruction issued with destination)
- sb_set_addr  input  AW  destination being claimed
- sb_flush  input  1  clear all busy bits (pipeline flush)
- sb_any_busy  output  1  OR of all busy bits

## Operation

- Storage: 2**AW x DW registers plus 2**AW busy bits.
- Reset (rst_n=0 at a rising edge): all registers <= 0, all busy <= 0. Reset takes priority over every other input. Reset mid-operation discards in-flight writes and busy claims.
- Write: for each port k with wr_en[k], mem[wr_addr_k] <= wr_data_k at the edge.
- Both write ports to the same address in one cycle: port NW-1 (highest index) wins.
- ZERO_REG=1: writes to address 0 are dropped. rd_data for address 0 is always 0. Busy bit 0 is never set.
- Read: rd_data_j = mem[rd_addr_j], combinational, no clock. rd_busy_j = busy[rd_addr_j], combinational.
- Scoreboard, per address a, evaluated each edge in priority order:
  1. rst_n=0 -> 0
  2. sb_flush -> 0. Flush also overrides a same-cycle sb_set.
  3. sb_set_en and sb_set_addr==a -> 1. Set wins over a same-cycle write clear, because a new producer was issued.
  4. any wr_en[k] with wr_addr_k==a -> 0
  5. otherwise hold.
- A write clears busy whether or not the bit was set. Writes during flush still update data.
- sb_any_busy is the combinational OR of the busy vector.

## Timing

- Write-to-read latency without bypass: 1 cycle. Data written at edge N is visible on rd_data after edge N.
- Scoreboard set or clear is visible on rd_busy after the edge.
- No handshake and no backpressure. The block accepts every write and set each cycle.
- All outputs during and after reset: rd_data=0 (all storage is 0), rd_busy=0, sb_any_busy=0.

## Configuration

- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-through forwarding.
  - If wr_en[k] and wr_addr_k==rd_addr_j (and the address is not 0 when ZERO_REG=1), rd_data_j = wr_data_k. The highest-index matching port wins.
  - rd_busy_j reads 0 when a same-cycle write matches, unless sb_set_en targets that address in the same cycle.
- Undefined: no forwarding. Reads return stored contents only. Decode must stall one extra cycle on writeback collisions.

## Test plan

- Reset then read all addresses: rst_n=0 for 2 cycles -> every rd_data=0, rd_busy=0, sb_any_busy=0. Repeat with prior nonzero contents -> still all 0.
- Write/read: wr_en[0]=1, addr 5, data 0xDEADBEEF -> next cycle rd_addr=5 returns 0xDEADBEEF. A write of 0x1234 to addr 0 with ZERO_REG=1 -> addr 0 reads 0.
- Dual-write conflict (NW=2): port0 writes 0xAAAA_AAAA and port1 writes 0x5555_5555 to addr 7 in the same cycle -> addr 7 reads 0x5555_5555.
- Scoreboard: sb_set addr 3 -> rd_busy=1 and sb_any_busy=1. Same-cycle sb_set addr 3 plus write addr 3 -> stays busy. Next write to addr 3 -> busy=0. sb_set addr 0 -> busy stays 0.
- Flush: set addrs 1, 2, 9, then sb_flush together with sb_set addr 4 -> all busy=0 including addr 4.
- Bypass (REGFILE_BYPASS_EN defined): write 0xCAFE_F00D to addr 12 while rd_addr=12 -> same-cycle rd_data=0xCAFE_F00D. With the macro undefined, the same stimulus returns the old value (0) that cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard detection.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int unsigned AW       = 5,
   parameter int unsigned DW       = 32,
   parameter int unsigned NR       = 2,
   parameter int unsigned NW       = 1,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NW-1:0]    wr_en,
   input  logic [NW*AW-1:0] wr_addr,
   input  logic [NW*DW-1:0] wr_data,
   input  logic [NR*AW-1:0] rd_addr,
   output logic [NR*DW-1:0] rd_data,
   output logic [NR-1:0]    rd_busy,
   input  logic             sb_set_en,
   input  logic [AW-1:0]    sb_set_addr,
   input  logic             sb_flush,
   output logic             sb_any_busy
);

   localparam int unsigned Depth = 2 ** AW;

   logic [DW-1:0]    mem_q [Depth];
   logic [DW-1:0]    mem_d [Depth];
   logic [Depth-1:0] busy_q;
   logic [Depth-1:0] busy_d;

   function automatic logic is_zero_reg(input logic [AW-1:0] addr);
      return ZERO_REG && (addr == '0);
   endfunction

   // Ports are visited in ascending order so the highest-index write port wins a collision.
   always_comb begin
      mem_d = mem_q;
      for (int unsigned k = 0; k < NW; k++) begin
         if (wr_en[k] && !is_zero_reg(wr_addr[k*AW +: AW])) begin
            mem_d[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
         end
      end
   end

   // Lowest priority is applied first: write clear, then set, then flush.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned k = 0; k < NW; k++) begin
         if (wr_en[k]) begin
            busy_d[wr_addr[k*AW +: AW]] = 1'b0;
         end
      end
      if (sb_set_en) begin
         busy_d[sb_set_addr] = 1'b1;
      end
      if (sb_flush) begin
         busy_d = '0;
      end
      if (ZERO_REG) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned a = 0; a < Depth; a++) begin
            mem_q[a] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int unsigned a = 0; a < Depth; a++) begin
            mem_q[a] <= mem_d[a];
         end
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned j = 0; j < NR; j++) begin
         rd_data[j*DW +: DW] = mem_q[rd_addr[j*AW +: AW]];
         rd_busy[j]          = busy_q[rd_addr[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
         for (int unsigned k = 0; k < NW; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr[j*AW +: AW]) &&
                !is_zero_reg(rd_addr[j*AW +: AW])) begin
               rd_data[j*DW +: DW] = wr_data[k*DW +: DW];
               // A producer issued this cycle keeps the register busy.
               if (!(sb_set_en && (sb_set_addr == rd_addr[j*AW +: AW]))) begin
                  rd_busy[j] = 1'b0;
               end
            end
         end
`endif
         if (is_zero_reg(rd_addr[j*AW +: AW])) begin
            rd_data[j*DW +: DW] = '0;
            rd_busy[j]          = 1'b0;
         end
      end
   end

   assign sb_any_busy = |busy_q;

endmodule
